sdram_dp_seq: RTL and testbench

- Sequences the SDRAM data path for one burst at a time.
- Generates output-enable and write data for the dq tristate driver during write bursts.
- Captures read data from the dq pins after CAS latency and presents it to the host.
- Sits between the SDRAM command FSM (which issues READ/WRITE commands) and the dq pad multiplexer.

---
 rtl/sdram_dp_seq_pkg.sv | 20 ++
 rtl/sdram_dp_seq_if.sv | 29 ++
 rtl/sdram_dp_seq_beat_cnt.sv | 34 +++
 rtl/sdram_dp_seq.sv | 138 +++++++++++++
 tb/tb_sdram_dp_seq.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_dp_seq_pkg.sv
// Shared types and constants for the SDRAM data-path sequencer.
// Holds the bus width, beat-counter width, state encoding and legal parameter ranges.
package sdram_dp_seq_pkg;

   localparam int DATA_SIZE     = 32;
   localparam int BURST_LEN_MAX = 8;
   localparam int BURST_LEN_DEF = 4;
   localparam int CAS_LAT_MIN   = 2;
   localparam int CAS_LAT_DEF   = 2;
   localparam int CNT_W         = $clog2(BURST_LEN_MAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WRITE    = 3'd1,
      S_CAS_WAIT = 3'd2,
      S_READ     = 3'd3,
      S_TURN     = 3'd4
   } seq_state_t;

endpackage

// File: rtl/sdram_dp_seq_if.sv
// Host/command-side and dq-pad-side signals of the data-path sequencer.
// The sequencer uses the slave view; whoever drives starts and dq uses the master view.
interface sdram_dp_seq_if;
   import sdram_dp_seq_pkg::*;

   logic                 wr_start;
   logic                 rd_start;
   logic [DATA_SIZE-1:0] host_wdata;
   logic                 wdata_ack;
   logic [DATA_SIZE-1:0] dq_in;
   logic [DATA_SIZE-1:0] sdram_out;
   logic                 oe;
   logic [DATA_SIZE-1:0] rd_data;
   logic                 rd_valid;
   logic                 busy;
   logic                 burst_done;
   logic                 seq_err;

   modport master (
      output wr_start, rd_start, host_wdata, dq_in,
      input  wdata_ack, sdram_out, oe, rd_data, rd_valid, busy, burst_done, seq_err
   );

   modport slave (
      input  wr_start, rd_start, host_wdata, dq_in,
      output wdata_ack, sdram_out, oe, rd_data, rd_valid, busy, burst_done, seq_err
   );

endinterface

// File: rtl/sdram_dp_seq_beat_cnt.sv
// Loadable up-counter with synchronous clear and terminal-count flag.
// Stops at the terminal count instead of wrapping; the owner decides what happens next.
module sdram_beat_cnt
   import sdram_dp_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_tc_val,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc && !o_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/sdram_dp_seq.sv
// SDRAM data-path sequencer: drives dq for write bursts and captures read beats
// after CAS latency, one burst at a time.
//
// state    | meaning
// IDLE     | waiting for wr_start / rd_start
// WRITE    | write beats on dq, oe asserted
// CAS_WAIT | waiting out CAS latency before the first read beat
// READ     | capturing read beats from dq_in
// TURN     | one-cycle bus turnaround after a write
module sdram_dp_seq
   import sdram_dp_seq_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CAS_LAT   = CAS_LAT_DEF
)(
   input logic           i_clk,
   input logic           i_reset,
   sdram_dp_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] BEAT_TC   = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] BEAT_PREV = CNT_W'(BURST_LEN - 2);
   localparam logic [CNT_W-1:0] CAS_TC    = CNT_W'(CAS_LAT - CAS_LAT_MIN);

   seq_state_t           r_state;
   logic                 r_oe;
   logic                 r_rd_valid;
   logic                 r_busy;
   logic                 r_burst_done;
   logic                 r_seq_err;
   logic [DATA_SIZE-1:0] r_sdram_out;
   logic [DATA_SIZE-1:0] r_rd_data;

   logic                 w_any_start;
   logic                 w_tc;
   logic                 w_cnt_clr;
   logic                 w_cnt_load;
   logic                 w_cnt_inc;
   logic [CNT_W-1:0]     w_cnt;
   logic [CNT_W-1:0]     w_tc_val;

   // One counter times both the CAS wait and the beats; its terminal value depends on the phase.
   assign w_any_start = bus.wr_start | bus.rd_start;
   assign w_tc_val    = (r_state == S_CAS_WAIT) ? CAS_TC : BEAT_TC;
   assign w_cnt_load  = ((r_state == S_IDLE) && w_any_start) ||
                        ((r_state == S_CAS_WAIT) && w_tc);
   assign w_cnt_clr   = (r_state == S_TURN) ||
                        (((r_state == S_WRITE) || (r_state == S_READ)) && w_tc);
   assign w_cnt_inc   = (r_state inside {S_WRITE, S_CAS_WAIT, S_READ}) && !w_tc;

   sdram_beat_cnt u_beat_cnt (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clr      (w_cnt_clr),
      .i_load     (w_cnt_load),
      .i_load_val ('0),
      .i_inc      (w_cnt_inc),
      .i_tc_val   (w_tc_val),
      .o_cnt      (w_cnt),
      .o_tc       (w_tc)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_oe         <= 1'b0;
         r_sdram_out  <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_burst_done <= 1'b0;
         r_seq_err    <= 1'b0;
      end else begin
         r_rd_valid   <= 1'b0;
         r_burst_done <= 1'b0;
         // Starts while busy are dropped; a collision in IDLE runs the write but is still flagged.
         r_seq_err    <= (r_state != S_IDLE) ? w_any_start : (bus.wr_start & bus.rd_start);
         unique case (r_state)
            S_IDLE: begin
               if (bus.wr_start) begin
                  r_state      <= S_WRITE;
                  r_busy       <= 1'b1;
                  r_oe         <= 1'b1;
                  r_sdram_out  <= bus.host_wdata;
                  r_burst_done <= (BURST_LEN == 1);
               end else if (bus.rd_start) begin
                  r_state <= S_CAS_WAIT;
                  r_busy  <= 1'b1;
               end
            end
            S_WRITE: begin
               if (w_tc) begin
                  r_state     <= S_TURN;
                  r_oe        <= 1'b0;
                  r_sdram_out <= '0;
               end else begin
                  r_oe         <= 1'b1;
                  r_sdram_out  <= bus.host_wdata;
                  r_burst_done <= (w_cnt == BEAT_PREV);
               end
            end
            S_CAS_WAIT: begin
               if (w_tc) r_state <= S_READ;
            end
            S_READ: begin
               r_rd_data  <= bus.dq_in;
               r_rd_valid <= 1'b1;
               if (w_tc) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_burst_done <= 1'b1;
               end
            end
            S_TURN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_oe        <= 1'b0;
               r_sdram_out <= '0;
            end
         endcase
      end
   end

   assign bus.wdata_ack  = ((r_state == S_IDLE) && bus.wr_start) ||
                           ((r_state == S_WRITE) && !w_tc);
   assign bus.sdram_out  = r_sdram_out;
   assign bus.oe         = r_oe;
   assign bus.rd_data    = r_rd_data;
   assign bus.rd_valid   = r_rd_valid;
   assign bus.busy       = r_busy;
   assign bus.burst_done = r_burst_done;
   assign bus.seq_err    = r_seq_err;

endmodule

// File: tb/tb_sdram_dp_seq.sv
// Bench for sdram_dp_seq: three instances (BL4/CL2, BL4/CL3, BL1/CL2) share one stimulus
// stream and are checked every cycle against a burst-timeline model, plus pinned literals.
module tb_sdram_dp_seq;
   import sdram_dp_seq_pkg::*;

   localparam int NCYC = 2600;
   localparam int NI   = 3;

   logic clk = 1'b0;
   logic tb_reset;
   logic tb_wr;
   logic tb_rd;
   logic [DATA_SIZE-1:0]         tb_wdata;
   logic [NI-1:0][DATA_SIZE-1:0] tb_dq;

   logic [NI-1:0] d_ack, d_oe, d_rv, d_busy, d_done, d_err;
   logic [NI-1:0][DATA_SIZE-1:0] d_out, d_rdata;

   always #5 clk = ~clk;

   function automatic int bl_of(input int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic int cl_of(input int i);
      return (i == 1) ? 3 : 2;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int BL = (g == 2) ? 1 : 4;
      localparam int CL = (g == 1) ? 3 : 2;
      sdram_dp_seq_if u_if ();
      sdram_dp_seq #(.BURST_LEN(BL), .CAS_LAT(CL)) u_dut (
         .i_clk   (clk),
         .i_reset (tb_reset),
         .bus     (u_if)
      );
      assign u_if.wr_start   = tb_wr;
      assign u_if.rd_start   = tb_rd;
      assign u_if.host_wdata = tb_wdata;
      assign u_if.dq_in      = tb_dq[g];
      assign d_ack[g]   = u_if.wdata_ack;
      assign d_oe[g]    = u_if.oe;
      assign d_rv[g]    = u_if.rd_valid;
      assign d_busy[g]  = u_if.busy;
      assign d_done[g]  = u_if.burst_done;
      assign d_err[g]   = u_if.seq_err;
      assign d_out[g]   = u_if.sdram_out;
      assign d_rdata[g] = u_if.rd_data;
   end

   // expected timeline per instance and cycle
   bit e_ack [NI][NCYC];
   bit e_oe  [NI][NCYC];
   bit e_rv  [NI][NCYC];
   bit e_busy[NI][NCYC];
   bit e_done[NI][NCYC];
   bit e_err [NI][NCYC];
   bit e_cap [NI][NCYC];
   logic [DATA_SIZE-1:0] e_out  [NI][NCYC];
   logic [DATA_SIZE-1:0] e_rdata[NI][NCYC];

   // observed DUT values, for the pinned literal checks
   bit o_oe  [NI][NCYC];
   bit o_rv  [NI][NCYC];
   bit o_busy[NI][NCYC];
   bit o_done[NI][NCYC];
   bit o_err [NI][NCYC];
   logic [DATA_SIZE-1:0] o_out  [NI][NCYC];
   logic [DATA_SIZE-1:0] o_rdata[NI][NCYC];

   int free_at[NI];
   bit was_rst;
   int cyc;
   int n_chk;
   int n_err;

   task automatic chk1(input string name, input int inst, input int c, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", name, inst, c, act, exp);
      end
   endtask

   task automatic chkw(input string name, input int inst, input int c,
                       input logic [DATA_SIZE-1:0] act, input logic [DATA_SIZE-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, inst, c, act, exp);
      end
   endtask

   task automatic model_step();
      int t;
      t = cyc;
      if (tb_reset) begin
         was_rst = 1'b1;
         return;
      end
      if (was_rst) begin
         for (int i = 0; i < NI; i++) begin
            for (int j = t; j < NCYC; j++) begin
               e_ack[i][j] = 0; e_oe[i][j] = 0; e_rv[i][j] = 0; e_busy[i][j] = 0;
               e_done[i][j] = 0; e_err[i][j] = 0; e_cap[i][j] = 0;
               e_out[i][j] = '0; e_rdata[i][j] = '0;
            end
            free_at[i] = t;
         end
         was_rst = 1'b0;
      end
      for (int i = 0; i < NI; i++) begin
         int bl;
         int cl;
         bl = bl_of(i);
         cl = cl_of(i);
         if (tb_wr || tb_rd) begin
            if (t < free_at[i]) begin
               e_err[i][t+1] = 1'b1;
            end else begin
               if (tb_wr && tb_rd) e_err[i][t+1] = 1'b1;
               if (tb_wr) begin
                  for (int k = 0; k < bl; k++) begin
                     e_ack[i][t+k]  = 1'b1;
                     e_oe[i][t+1+k] = 1'b1;
                  end
                  e_done[i][t+bl] = 1'b1;
                  for (int j = t + 1; j <= t + bl + 1; j++) e_busy[i][j] = 1'b1;
                  free_at[i] = t + bl + 2;
               end else begin
                  for (int k = 0; k < bl; k++) begin
                     e_cap[i][t+cl+k]  = 1'b1;
                     e_rv[i][t+cl+1+k] = 1'b1;
                  end
                  e_done[i][t+cl+bl] = 1'b1;
                  for (int j = t + 1; j < t + cl + bl; j++) e_busy[i][j] = 1'b1;
                  free_at[i] = t + cl + bl;
               end
            end
         end
         if (e_ack[i][t]) e_out[i][t+1] = tb_wdata;
         if (e_cap[i][t]) e_rdata[i][t+1] = tb_dq[i];

         chk1("wdata_ack",  i, t, d_ack[i],  e_ack[i][t]);
         chk1("oe",         i, t, d_oe[i],   e_oe[i][t]);
         chk1("busy",       i, t, d_busy[i], e_busy[i][t]);
         chk1("burst_done", i, t, d_done[i], e_done[i][t]);
         chk1("seq_err",    i, t, d_err[i],  e_err[i][t]);
         chk1("rd_valid",   i, t, d_rv[i],   e_rv[i][t]);
         if (e_oe[i][t]) chkw("sdram_out", i, t, d_out[i], e_out[i][t]);
         if (e_rv[i][t]) chkw("rd_data",   i, t, d_rdata[i], e_rdata[i][t]);

         o_oe[i][t]    = d_oe[i];
         o_rv[i][t]    = d_rv[i];
         o_busy[i][t]  = d_busy[i];
         o_done[i][t]  = d_done[i];
         o_err[i][t]   = d_err[i];
         o_out[i][t]   = d_out[i];
         o_rdata[i][t] = d_rdata[i];
      end
   endtask

   task automatic literal_checks();
      // BL4 write at 10: beats A0..A3 on cycles 11-14
      chk1("lit_wr_oe_pre", 0, 10, o_oe[0][10], 1'b0);
      for (int c = 11; c <= 14; c++) begin
         chk1("lit_wr_oe", 0, c, o_oe[0][c], 1'b1);
         chkw("lit_wr_data", 0, c, o_out[0][c], 32'hA0 + 32'(c - 11));
      end
      chk1("lit_wr_done",  0, 14, o_done[0][14], 1'b1);
      chk1("lit_wr_turn",  0, 15, o_oe[0][15],   1'b0);
      chk1("lit_turn_busy",0, 15, o_busy[0][15], 1'b1);
      chk1("lit_idle",     0, 16, o_busy[0][16], 1'b0);
      // CL2 read at 20 -> valid 23-26; CL3 -> valid 24-27
      chk1("lit_rd2_pre",  0, 22, o_rv[0][22], 1'b0);
      chk1("lit_rd2_post", 0, 27, o_rv[0][27], 1'b0);
      chk1("lit_rd3_pre",  1, 23, o_rv[1][23], 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk1("lit_rd2_valid", 0, 23 + k, o_rv[0][23+k], 1'b1);
         chkw("lit_rd2_data",  0, 23 + k, o_rdata[0][23+k], 32'hB0 + 32'(k));
         chk1("lit_rd3_valid", 1, 24 + k, o_rv[1][24+k], 1'b1);
         chkw("lit_rd3_data",  1, 24 + k, o_rdata[1][24+k], 32'hB0 + 32'(k));
      end
      chk1("lit_rd2_done", 0, 26, o_done[0][26], 1'b1);
      for (int c = 20; c <= 27; c++) chk1("lit_rd_no_oe", 0, c, o_oe[0][c], 1'b0);
      // BL1 write at 10
      chk1("lit_bl1_oe",    2, 11, o_oe[2][11], 1'b1);
      chkw("lit_bl1_data",  2, 11, o_out[2][11], 32'hA0);
      chk1("lit_bl1_done",  2, 11, o_done[2][11], 1'b1);
      chk1("lit_bl1_oe_off",2, 12, o_oe[2][12], 1'b0);
      chk1("lit_bl1_turn",  2, 12, o_busy[2][12], 1'b1);
      chk1("lit_bl1_idle",  2, 13, o_busy[2][13], 1'b0);
      // collision at 30, busy read at 32
      chk1("lit_coll_err",  0, 31, o_err[0][31], 1'b1);
      chk1("lit_coll_wr",   0, 31, o_oe[0][31],  1'b1);
      chk1("lit_noerr",     0, 32, o_err[0][32], 1'b0);
      chk1("lit_busy_err",  0, 33, o_err[0][33], 1'b1);
      chk1("lit_bl1_turn_err", 2, 33, o_err[2][33], 1'b1);
      // read after mid-write reset
      for (int k = 0; k < 4; k++) chk1("lit_post_rst_valid", 0, 53 + k, o_rv[0][53+k], 1'b1);
      chkw("lit_post_rst_data", 0, 56, o_rdata[0][56], 32'hC3);
   endtask

   initial begin
      tb_reset = 1'b1;
      tb_wr    = 1'b0;
      tb_rd    = 1'b0;
      tb_wdata = '0;
      tb_dq    = '0;
      cyc      = 0;
      n_chk    = 0;
      n_err    = 0;
      was_rst  = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk1("rst_oe",         i, 1, d_oe[i],   1'b0);
         chk1("rst_busy",       i, 1, d_busy[i], 1'b0);
         chk1("rst_done",       i, 1, d_done[i], 1'b0);
         chk1("rst_err",        i, 1, d_err[i],  1'b0);
         chk1("rst_rd_valid",   i, 1, d_rv[i],   1'b0);
         chk1("rst_ack",        i, 1, d_ack[i],  1'b0);
         chkw("rst_sdram_out",  i, 1, d_out[i],  '0);
         chkw("rst_rd_data",    i, 1, d_rdata[i], '0);
      end

      for (int n = 2; n < NCYC - 10; n++) begin
         @(posedge clk);
         cyc = n;
         #1;
         if (n == 2 || n == 44) tb_reset = 1'b0;
         if (n < 60) begin
            tb_wr    = (n == 10) || (n == 30) || (n == 40);
            tb_rd    = (n == 20) || (n == 30) || (n == 32) || (n == 50);
            tb_wdata = (n >= 10 && n <= 13) ? 32'hA0 + 32'(n - 10) : $urandom;
            tb_dq[0] = (n >= 22 && n <= 25) ? 32'hB0 + 32'(n - 22) :
                       (n >= 52 && n <= 55) ? 32'hC0 + 32'(n - 52) : $urandom;
            tb_dq[1] = (n >= 23 && n <= 26) ? 32'hB0 + 32'(n - 23) : $urandom;
            tb_dq[2] = $urandom;
         end else begin
            tb_wr    = (n < NCYC - 40) && ($urandom_range(0, 5) == 0);
            tb_rd    = (n < NCYC - 40) && ($urandom_range(0, 5) == 0);
            tb_wdata = $urandom;
            for (int i = 0; i < NI; i++) tb_dq[i] = $urandom;
         end
         if (n == 43) begin
            chk1("pre_rst_oe", 0, n, d_oe[0], 1'b1);
            #2;
            tb_reset = 1'b1;
            #1;
            for (int i = 0; i < NI; i++) begin
               chk1("async_rst_oe",   i, n, d_oe[i],   1'b0);
               chk1("async_rst_busy", i, n, d_busy[i], 1'b0);
            end
         end
         @(negedge clk);
         model_step();
         if (n == 58) literal_checks();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
